ahb_lite_master: RTL and testbench



---
 rtl/ahb_pkg.sv | 21 ++
 rtl/ahb_lite_master.sv | 75 +++++++
 tb/tb_ahb_lite_master.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB-Lite encodings shared by the peripheral bus master and its slaves.
package ahb_pkg;
  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;
  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HSIZE_BYTE    = 3'b000;
  localparam logic [2:0] HSIZE_HALF    = 3'b001;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  // Sizes wider than a word are unsupported on this bus and count as misaligned.
  function automatic logic misaligned(input logic [2:0] size, input logic [1:0] lo);
    return (size == HSIZE_HALF) ? lo[0] : (size == HSIZE_WORD) ? |lo : (size > HSIZE_WORD);
  endfunction
endpackage

// File: rtl/ahb_lite_master.sv
// ahb_lite_master: req/gnt/rsp to single AHB-Lite transfers, pipelined A/D slots.
module ahb_lite_master
  import ahb_pkg::*;
#(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [AWIDTH-1:0] addr_i,
  input  logic [2:0]        size_i,
  input  logic [DWIDTH-1:0] wdata_i,
  output logic              gnt_o,
  output logic              rsp_valid_o,
  output logic              rsp_err_o,
  output logic [DWIDTH-1:0] rdata_o,
  output logic [AWIDTH-1:0] haddr_o,
  output logic [1:0]        htrans_o,
  output logic              hwrite_o,
  output logic [2:0]        hsize_o,
  output logic [2:0]        hburst_o,
  output logic [DWIDTH-1:0] hwdata_o,
  input  logic [DWIDTH-1:0] hrdata_i,
  input  logic              hready_i,
  input  logic              hresp_i
);
  logic              a_valid, a_mis, d_valid, d_write, d_mis, err_pend;
  logic [DWIDTH-1:0] a_wdata;
  logic              a_move, d_done;
  assign a_move   = a_valid && hready_i;
  assign d_done   = d_valid && hready_i;
  assign gnt_o    = req_i && !err_pend && (!a_valid || hready_i);
  assign htrans_o = (a_valid && !a_mis && !err_pend) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign hburst_o = HBURST_SINGLE;
  // An A-slot entry that moves while err_pend is set is the cancelled one; it rides on as a dummy.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      a_valid     <= 1'b0;
      a_mis       <= 1'b0;
      haddr_o     <= '0;
      hwrite_o    <= 1'b0;
      hsize_o     <= '0;
      a_wdata     <= '0;
      d_valid     <= 1'b0;
      d_write     <= 1'b0;
      d_mis       <= 1'b0;
      hwdata_o    <= '0;
      err_pend    <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rdata_o     <= '0;
    end else begin
      if (gnt_o) begin
        a_valid  <= 1'b1;
        a_mis    <= misaligned(size_i, addr_i[1:0]);
        haddr_o  <= addr_i;
        hwrite_o <= we_i;
        hsize_o  <= size_i;
        a_wdata  <= wdata_i;
      end else if (a_move) a_valid <= 1'b0;
      if (a_move) begin
        d_valid  <= 1'b1;
        d_write  <= hwrite_o;
        d_mis    <= a_mis || err_pend;
        hwdata_o <= a_wdata;
      end else if (d_done) d_valid <= 1'b0;
      err_pend    <= err_pend ? !hready_i : (d_valid && hresp_i && !hready_i);
      rsp_valid_o <= d_done;
      rsp_err_o   <= d_done && (hresp_i || d_mis);
      if (d_done && !d_write && !d_mis) rdata_o <= hrdata_i;
    end
  end
endmodule

// File: tb/tb_ahb_lite_master.sv
// tb_ahb_lite_master: directed scenario tests for ahb_lite_master with hand-derived expectations.
module tb_ahb_lite_master;
  logic        hclk = 1'b0, hreset = 1'b1;
  logic        req_i = 1'b0, we_i = 1'b0;
  logic [31:0] addr_i = '0, wdata_i = '0, hrdata_i = '0;
  logic [2:0]  size_i = '0;
  logic        hready_i = 1'b1, hresp_i = 1'b0;
  logic        gnt_o, rsp_valid_o, rsp_err_o, hwrite_o;
  logic [31:0] rdata_o, haddr_o, hwdata_o;
  logic [1:0]  htrans_o;
  logic [2:0]  hsize_o, hburst_o;
  int pass = 0, total = 0;

  ahb_lite_master dut (
    .hclk(hclk), .hreset(hreset), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .size_i(size_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rsp_valid_o(rsp_valid_o),
    .rsp_err_o(rsp_err_o), .rdata_o(rdata_o), .haddr_o(haddr_o), .htrans_o(htrans_o),
    .hwrite_o(hwrite_o), .hsize_o(hsize_o), .hburst_o(hburst_o), .hwdata_o(hwdata_o),
    .hrdata_i(hrdata_i), .hready_i(hready_i), .hresp_i(hresp_i)
  );

  always #5 hclk = ~hclk;

  task automatic step();
    @(negedge hclk);
  endtask

  task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
    req_i = r; we_i = w; addr_i = a; size_i = s; wdata_i = d;
    #1;
  endtask

  task automatic test_reset();
    hreset = 1'b1;
    step(); step();
    total++; if (htrans_o !== 2'b00) $display("FAIL rst_htrans got %h exp 0", htrans_o); else pass++;
    total++; if (haddr_o !== 32'h0) $display("FAIL rst_haddr got %h exp 0", haddr_o); else pass++;
    total++; if (hwrite_o !== 1'b0) $display("FAIL rst_hwrite got %b exp 0", hwrite_o); else pass++;
    total++; if (hsize_o !== 3'd0) $display("FAIL rst_hsize got %h exp 0", hsize_o); else pass++;
    total++; if (hwdata_o !== 32'h0) $display("FAIL rst_hwdata got %h exp 0", hwdata_o); else pass++;
    total++; if (rsp_valid_o !== 1'b0) $display("FAIL rst_rsp_valid got %b exp 0", rsp_valid_o); else pass++;
    total++; if (rsp_err_o !== 1'b0) $display("FAIL rst_rsp_err got %b exp 0", rsp_err_o); else pass++;
    total++; if (rdata_o !== 32'h0) $display("FAIL rst_rdata got %h exp 0", rdata_o); else pass++;
    total++; if (hburst_o !== 3'd0) $display("FAIL rst_hburst got %h exp 0", hburst_o); else pass++;
    hreset = 1'b0;
  endtask

  task automatic test_write();
    step(); drive(1, 1, 32'h1000_0008, 3'd2, 32'hDEAD_BEEF);
    total++; if (gnt_o !== 1'b1) $display("FAIL wr_gnt got %b exp 1", gnt_o); else pass++;
    total++; if (htrans_o !== 2'b00) $display("FAIL wr_idle_before got %h exp 0", htrans_o); else pass++;
    step(); drive(0, 0, 0, 0, 0);
    total++; if (htrans_o !== 2'b10) $display("FAIL wr_nonseq got %h exp 2", htrans_o); else pass++;
    total++; if (haddr_o !== 32'h1000_0008) $display("FAIL wr_haddr got %h exp 10000008", haddr_o); else pass++;
    total++; if (hwrite_o !== 1'b1) $display("FAIL wr_hwrite got %b exp 1", hwrite_o); else pass++;
    total++; if (hsize_o !== 3'd2) $display("FAIL wr_hsize got %h exp 2", hsize_o); else pass++;
    step();
    total++; if (htrans_o !== 2'b00) $display("FAIL wr_idle_after got %h exp 0", htrans_o); else pass++;
    total++; if (hwdata_o !== 32'hDEAD_BEEF) $display("FAIL wr_hwdata got %h exp deadbeef", hwdata_o); else pass++;
    total++; if (rsp_valid_o !== 1'b0) $display("FAIL wr_rsp_early got %b exp 0", rsp_valid_o); else pass++;
    step();
    total++; if (rsp_valid_o !== 1'b1) $display("FAIL wr_rsp got %b exp 1", rsp_valid_o); else pass++;
    total++; if (rsp_err_o !== 1'b0) $display("FAIL wr_rsp_err got %b exp 0", rsp_err_o); else pass++;
    step();
    total++; if (rsp_valid_o !== 1'b0) $display("FAIL wr_rsp_once got %b exp 0", rsp_valid_o); else pass++;
  endtask

  task automatic test_read_wait();
    step(); drive(1, 0, 32'h1000_0004, 3'd2, 0);
    total++; if (gnt_o !== 1'b1) $display("FAIL rd_gnt got %b exp 1", gnt_o); else pass++;
    step(); drive(0, 0, 0, 0, 0);
    total++; if (htrans_o !== 2'b10) $display("FAIL rd_nonseq got %h exp 2", htrans_o); else pass++;
    total++; if (hwrite_o !== 1'b0) $display("FAIL rd_hwrite got %b exp 0", hwrite_o); else pass++;
    step(); hready_i = 1'b0;
    total++; if (htrans_o !== 2'b00) $display("FAIL rd_idle got %h exp 0", htrans_o); else pass++;
    total++; if (rsp_valid_o !== 1'b0) $display("FAIL rd_rsp_w1 got %b exp 0", rsp_valid_o); else pass++;
    step();
    total++; if (rsp_valid_o !== 1'b0) $display("FAIL rd_rsp_w2 got %b exp 0", rsp_valid_o); else pass++;
    step(); hready_i = 1'b1; hrdata_i = 32'h0000_0005;
    total++; if (rsp_valid_o !== 1'b0) $display("FAIL rd_rsp_w3 got %b exp 0", rsp_valid_o); else pass++;
    step(); hrdata_i = 32'h0;
    total++; if (rsp_valid_o !== 1'b1) $display("FAIL rd_rsp got %b exp 1", rsp_valid_o); else pass++;
    total++; if (rdata_o !== 32'h5) $display("FAIL rd_rdata got %h exp 5", rdata_o); else pass++;
    total++; if (rsp_err_o !== 1'b0) $display("FAIL rd_err got %b exp 0", rsp_err_o); else pass++;
    step();
    total++; if (rsp_valid_o !== 1'b0) $display("FAIL rd_rsp_once got %b exp 0", rsp_valid_o); else pass++;
    total++; if (rdata_o !== 32'h5) $display("FAIL rd_rdata_hold got %h exp 5", rdata_o); else pass++;
  endtask

  task automatic test_back_to_back();
    step(); drive(1, 1, 32'h0, 3'd2, 32'hAAAA_0000);
    total++; if (gnt_o !== 1'b1) $display("FAIL b2b_gnt0 got %b exp 1", gnt_o); else pass++;
    step(); drive(1, 1, 32'h4, 3'd2, 32'hBBBB_0004);
    total++; if (gnt_o !== 1'b1) $display("FAIL b2b_gnt1 got %b exp 1", gnt_o); else pass++;
    total++; if (htrans_o !== 2'b10 || haddr_o !== 32'h0) $display("FAIL b2b_a0 got %h/%h exp 2/0", htrans_o, haddr_o); else pass++;
    step(); drive(1, 1, 32'h8, 3'd2, 32'hCCCC_0008);
    total++; if (gnt_o !== 1'b1) $display("FAIL b2b_gnt2 got %b exp 1", gnt_o); else pass++;
    total++; if (htrans_o !== 2'b10 || haddr_o !== 32'h4) $display("FAIL b2b_a1 got %h/%h exp 2/4", htrans_o, haddr_o); else pass++;
    total++; if (hwdata_o !== 32'hAAAA_0000) $display("FAIL b2b_d0 got %h exp aaaa0000", hwdata_o); else pass++;
    step(); drive(0, 0, 0, 0, 0);
    total++; if (htrans_o !== 2'b10 || haddr_o !== 32'h8) $display("FAIL b2b_a2 got %h/%h exp 2/8", htrans_o, haddr_o); else pass++;
    total++; if (hwdata_o !== 32'hBBBB_0004) $display("FAIL b2b_d1 got %h exp bbbb0004", hwdata_o); else pass++;
    total++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b0) $display("FAIL b2b_rsp0 got %b/%b exp 1/0", rsp_valid_o, rsp_err_o); else pass++;
    step();
    total++; if (htrans_o !== 2'b00) $display("FAIL b2b_idle got %h exp 0", htrans_o); else pass++;
    total++; if (hwdata_o !== 32'hCCCC_0008) $display("FAIL b2b_d2 got %h exp cccc0008", hwdata_o); else pass++;
    total++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b0) $display("FAIL b2b_rsp1 got %b/%b exp 1/0", rsp_valid_o, rsp_err_o); else pass++;
    step();
    total++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b0) $display("FAIL b2b_rsp2 got %b/%b exp 1/0", rsp_valid_o, rsp_err_o); else pass++;
    step();
    total++; if (rsp_valid_o !== 1'b0) $display("FAIL b2b_rsp_end got %b exp 0", rsp_valid_o); else pass++;
  endtask

  task automatic test_error();
    step(); drive(1, 0, 32'h0, 3'd2, 0);
    total++; if (gnt_o !== 1'b1) $display("FAIL err_gnt_rd got %b exp 1", gnt_o); else pass++;
    step(); drive(1, 1, 32'h4, 3'd2, 32'h1234);
    total++; if (gnt_o !== 1'b1) $display("FAIL err_gnt_wr got %b exp 1", gnt_o); else pass++;
    total++; if (htrans_o !== 2'b10 || haddr_o !== 32'h0) $display("FAIL err_rd_addr got %h/%h exp 2/0", htrans_o, haddr_o); else pass++;
    step(); drive(0, 0, 0, 0, 0); hresp_i = 1'b1; hready_i = 1'b0;
    total++; if (gnt_o !== 1'b0) $display("FAIL err_gnt_wait got %b exp 0", gnt_o); else pass++;
    step(); drive(1, 0, 32'h20, 3'd2, 0); hready_i = 1'b1;
    total++; if (htrans_o !== 2'b00) $display("FAIL err_cancel_idle got %h exp 0", htrans_o); else pass++;
    total++; if (gnt_o !== 1'b0) $display("FAIL err_gnt_blocked got %b exp 0", gnt_o); else pass++;
    total++; if (rsp_valid_o !== 1'b0) $display("FAIL err_rsp_early got %b exp 0", rsp_valid_o); else pass++;
    step(); drive(0, 0, 0, 0, 0); hresp_i = 1'b0;
    total++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b1) $display("FAIL err_rsp_rd got %b/%b exp 1/1", rsp_valid_o, rsp_err_o); else pass++;
    total++; if (htrans_o !== 2'b00) $display("FAIL err_wr_not_issued got %h exp 0", htrans_o); else pass++;
    step();
    total++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b1) $display("FAIL err_rsp_wr got %b/%b exp 1/1", rsp_valid_o, rsp_err_o); else pass++;
    total++; if (htrans_o !== 2'b00) $display("FAIL err_idle_after got %h exp 0", htrans_o); else pass++;
    step();
    total++; if (rsp_valid_o !== 1'b0) $display("FAIL err_rsp_end got %b exp 0", rsp_valid_o); else pass++;
  endtask

  task automatic test_misaligned();
    step(); drive(1, 0, 32'h2, 3'd2, 0);
    total++; if (gnt_o !== 1'b1) $display("FAIL mis_gnt_word got %b exp 1", gnt_o); else pass++;
    step(); drive(1, 1, 32'h1, 3'd1, 32'h55);
    total++; if (gnt_o !== 1'b1) $display("FAIL mis_gnt_half got %b exp 1", gnt_o); else pass++;
    total++; if (htrans_o !== 2'b00) $display("FAIL mis_word_idle got %h exp 0", htrans_o); else pass++;
    step(); drive(0, 0, 0, 0, 0);
    total++; if (htrans_o !== 2'b00) $display("FAIL mis_half_idle got %h exp 0", htrans_o); else pass++;
    step();
    total++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b1) $display("FAIL mis_rsp_word got %b/%b exp 1/1", rsp_valid_o, rsp_err_o); else pass++;
    step(); drive(1, 0, 32'hC, 3'd2, 0);
    total++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b1) $display("FAIL mis_rsp_half got %b/%b exp 1/1", rsp_valid_o, rsp_err_o); else pass++;
    total++; if (gnt_o !== 1'b1) $display("FAIL mis_gnt_next got %b exp 1", gnt_o); else pass++;
    step(); drive(0, 0, 0, 0, 0);
    total++; if (htrans_o !== 2'b10 || haddr_o !== 32'hC) $display("FAIL mis_next_addr got %h/%h exp 2/c", htrans_o, haddr_o); else pass++;
    total++; if (rsp_valid_o !== 1'b0) $display("FAIL mis_rsp_gap got %b exp 0", rsp_valid_o); else pass++;
    step(); hrdata_i = 32'h77;
    step(); hrdata_i = 32'h0;
    total++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b0) $display("FAIL mis_next_rsp got %b/%b exp 1/0", rsp_valid_o, rsp_err_o); else pass++;
    total++; if (rdata_o !== 32'h77) $display("FAIL mis_next_rdata got %h exp 77", rdata_o); else pass++;
  endtask

  task automatic test_reset_mid();
    step(); drive(1, 0, 32'h40, 3'd2, 0);
    step(); drive(0, 0, 0, 0, 0);
    total++; if (htrans_o !== 2'b10) $display("FAIL rm_nonseq got %h exp 2", htrans_o); else pass++;
    step(); hready_i = 1'b0;
    step(); hreset = 1'b1;
    step(); hreset = 1'b0; hready_i = 1'b1;
    total++; if (htrans_o !== 2'b00) $display("FAIL rm_idle got %h exp 0", htrans_o); else pass++;
    total++; if (rsp_valid_o !== 1'b0) $display("FAIL rm_no_rsp got %b exp 0", rsp_valid_o); else pass++;
    step(); drive(1, 1, 32'h44, 3'd2, 32'h99);
    total++; if (rsp_valid_o !== 1'b0) $display("FAIL rm_no_late_rsp got %b exp 0", rsp_valid_o); else pass++;
    total++; if (gnt_o !== 1'b1) $display("FAIL rm_gnt got %b exp 1", gnt_o); else pass++;
    step(); drive(0, 0, 0, 0, 0);
    total++; if (htrans_o !== 2'b10 || haddr_o !== 32'h44) $display("FAIL rm_new_addr got %h/%h exp 2/44", htrans_o, haddr_o); else pass++;
    step();
    total++; if (hwdata_o !== 32'h99) $display("FAIL rm_new_hwdata got %h exp 99", hwdata_o); else pass++;
    step();
    total++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b0) $display("FAIL rm_new_rsp got %b/%b exp 1/0", rsp_valid_o, rsp_err_o); else pass++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_back_to_back();
    test_error();
    test_misaligned();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
